// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the regfile write scheduler.
// Optional feature macro used by regfile_wr_sched: RFWS_X0_DROP_EN.
package regfile_pkg;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 64;
    localparam int unsigned NREG = 1 << AW;

    typedef enum logic {
        INIT,
        RUN
    } rfwsState_e;

endpackage

// File: rtl/rfws_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module rfws_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grantIdx,
    output logic            anyValid
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!found && valid[idx]) begin
                found    = 1'b1;
                grant    = {{(NREQ-1){1'b0}}, 1'b1} << idx;
                grantIdx = IW'(idx);
            end
        end
    end

    assign anyValid = |valid;

endmodule

// File: rtl/regfile_wr_sched.sv
// Write scheduler for regfile_32x64: post-reset clear sweep, then round-robin arbitration.
// Define RFWS_X0_DROP_EN to suppress RUN-time writes that target register 0.
module regfile_wr_sched
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = regfile_pkg::AW,
    parameter int unsigned DW   = regfile_pkg::DW,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               w,
    output logic [AW-1:0]      wa,
    output logic [DW-1:0]      wd,
    output logic [IW-1:0]      grant_id,
    output logic               init_done
);

    rfwsState_e    stateQ, stateD;
    logic [AW-1:0] cntQ, cntD;
    logic [IW-1:0] ptrQ, ptrD;
    logic          wQ, wD;
    logic [AW-1:0] waQ, waD;
    logic [DW-1:0] wdQ, wdD;
    logic [IW-1:0] gidQ, gidD;
    logic          initDoneQ, initDoneD;

    logic [NREQ-1:0] pickGrant;
    logic [IW-1:0]   pickIdx;
    logic            pickAny;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selData;
    logic            running;

    rfws_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .valid    (req_valid),
        .ptr      (ptrQ),
        .grant    (pickGrant),
        .grantIdx (pickIdx),
        .anyValid (pickAny)
    );

    assign selAddr = req_addr[pickIdx*AW +: AW];
    assign selData = req_data[pickIdx*DW +: DW];

    // Ready is gated by rst directly so no handshake can complete in a reset cycle.
    assign running   = (stateQ == RUN) && rst;
    assign req_ready = running ? pickGrant : '0;

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        ptrD      = ptrQ;
        wD        = 1'b0;
        waD       = waQ;
        wdD       = wdQ;
        gidD      = gidQ;
        initDoneD = initDoneQ;
        unique case (stateQ)
            INIT: begin
                wD   = 1'b1;
                waD  = cntQ;
                wdD  = '0;
                cntD = cntQ + AW'(1);
                if (cntQ == '1) begin
                    stateD    = RUN;
                    initDoneD = 1'b1;
                end
            end
            RUN: begin
                if (pickAny) begin
`ifdef RFWS_X0_DROP_EN
                    wD = (selAddr != '0);
`else
                    wD = 1'b1;
`endif
                    waD  = selAddr;
                    wdD  = selData;
                    gidD = pickIdx;
                    ptrD = (pickIdx == IW'(NREQ - 1)) ? '0 : pickIdx + IW'(1);
                end
            end
            default: stateD = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ    <= INIT;
            cntQ      <= '0;
            ptrQ      <= '0;
            wQ        <= 1'b0;
            waQ       <= '0;
            wdQ       <= '0;
            gidQ      <= '0;
            initDoneQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            ptrQ      <= ptrD;
            wQ        <= wD;
            waQ       <= waD;
            wdQ       <= wdD;
            gidQ      <= gidD;
            initDoneQ <= initDoneD;
        end
    end

    assign w         = wQ;
    assign wa        = waQ;
    assign wd        = wdQ;
    assign grant_id  = gidQ;
    assign init_done = initDoneQ;

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched with a behavioural 32x64 register file on the write port.
module tb_regfile_wr_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 64;
    localparam int unsigned IW   = 2;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               w;
    logic [AW-1:0]      wa;
    logic [DW-1:0]      wd;
    logic [IW-1:0]      grant_id;
    logic               init_done;

    logic [DW-1:0] mem [32];

    int nChecks;
    int nFails;

    regfile_wr_sched #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .w         (w),
        .wa        (wa),
        .wd        (wd),
        .grant_id  (grant_id),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model commits at the end of the cycle in which w is high.
    always @(posedge clk) begin
        if (w) mem[wa] <= wd;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        req_valid = 4'b1111;
        #1;
        nChecks++;
        if (req_ready !== 4'b0000) begin
            nFails++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        nChecks++;
        if ({w, wa, wd, grant_id, init_done} !== '0) begin
            nFails++;
            $display("FAIL reset_outputs: w=%b wa=%0d wd=%h gid=%0d done=%b want all 0",
                     w, wa, wd, grant_id, init_done);
        end
        step();
        req_valid = '0;
    endtask

    task automatic test_sweep();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            nChecks++;
            if (w !== 1'b1 || wa !== AW'(i) || wd !== '0) begin
                nFails++;
                $display("FAIL sweep_write[%0d]: w=%b wa=%0d wd=%h want w=1 wa=%0d wd=0",
                         i, w, wa, wd, i);
            end
            nChecks++;
            if (init_done !== (i == 31) || req_ready !== 4'b0000) begin
                nFails++;
                $display("FAIL sweep_status[%0d]: done=%b ready=%b want done=%b ready=0000",
                         i, init_done, req_ready, (i == 31));
            end
        end
        step();
        nChecks++;
        if (w !== 1'b0 || init_done !== 1'b1 || mem[31] !== '0) begin
            nFails++;
            $display("FAIL sweep_end: w=%b done=%b reg31=%h want w=0 done=1 reg31=0",
                     w, init_done, mem[31]);
        end
    endtask

    task automatic test_single();
        req_addr[0*AW +: AW] = 5'd11;
        req_data[0*DW +: DW] = 64'd11;
        req_valid = 4'b0001;
        #1;
        nChecks++;
        if (req_ready !== 4'b0001) begin
            nFails++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        nChecks++;
        if (w !== 1'b1 || wa !== 5'd11 || wd !== 64'd11 || grant_id !== 2'd0) begin
            nFails++;
            $display("FAIL single_write: w=%b wa=%0d wd=%0d gid=%0d want 1/11/11/0",
                     w, wa, wd, grant_id);
        end
        step();
        nChecks++;
        if (w !== 1'b0 || mem[11] !== 64'd11) begin
            nFails++;
            $display("FAIL single_read: w=%b reg11=%0d want w=0 reg11=11", w, mem[11]);
        end
    endtask

    task automatic test_x0();
        req_addr[3*AW +: AW] = 5'd0;
        req_data[3*DW +: DW] = 64'hFFFF;
        req_valid = 4'b1000;
        #1;
        nChecks++;
        if (req_ready !== 4'b1000) begin
            nFails++;
            $display("FAIL x0_ready: got %b want 1000", req_ready);
        end
        step();
        req_valid = '0;
`ifdef RFWS_X0_DROP_EN
        nChecks++;
        if (w !== 1'b0) begin
            nFails++;
            $display("FAIL x0_drop: w=%b want 0", w);
        end
        step();
        nChecks++;
        if (mem[0] !== 64'd0) begin
            nFails++;
            $display("FAIL x0_reg0: got %h want 0", mem[0]);
        end
`else
        nChecks++;
        if (w !== 1'b1 || wa !== 5'd0 || wd !== 64'hFFFF || grant_id !== 2'd3) begin
            nFails++;
            $display("FAIL x0_write: w=%b wa=%0d wd=%h gid=%0d want 1/0/ffff/3",
                     w, wa, wd, grant_id);
        end
        step();
        nChecks++;
        if (mem[0] !== 64'hFFFF) begin
            nFails++;
            $display("FAIL x0_reg0: got %h want ffff", mem[0]);
        end
`endif
    endtask

    task automatic test_contention();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*AW +: AW] = AW'(i + 1);
            req_data[i*DW +: DW] = DW'(32'hA0 + i);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            nChecks++;
            if (req_ready !== (4'b0001 << k)) begin
                nFails++;
                $display("FAIL contention_ready[%0d]: got %b want %b",
                         k, req_ready, 4'b0001 << k);
            end
            step();
            nChecks++;
            if (w !== 1'b1 || grant_id !== IW'(k) || wa !== AW'(k + 1) ||
                wd !== DW'(32'hA0 + k)) begin
                nFails++;
                $display("FAIL contention_write[%0d]: w=%b gid=%0d wa=%0d wd=%h want 1/%0d/%0d/%h",
                         k, w, grant_id, wa, wd, k, k + 1, 32'hA0 + k);
            end
        end
        req_valid = '0;
        step();
        nChecks++;
        if (w !== 1'b0 || grant_id !== 2'd3 || wa !== 5'd4 || wd !== 64'hA3) begin
            nFails++;
            $display("FAIL idle_hold: w=%b gid=%0d wa=%0d wd=%h want 0/3/4/a3",
                     w, grant_id, wa, wd);
        end
    endtask

    task automatic test_fairness();
        req_addr[1*AW +: AW] = 5'd7;
        req_data[1*DW +: DW] = 64'h71;
        req_addr[2*AW +: AW] = 5'd7;
        req_data[2*DW +: DW] = 64'h72;
        req_valid = 4'b0110;
        #1;
        nChecks++;
        if (req_ready !== 4'b0010) begin
            nFails++;
            $display("FAIL fair_ready0: got %b want 0010", req_ready);
        end
        step();
        req_data[1*DW +: DW] = 64'h73;
        #1;
        nChecks++;
        if (grant_id !== 2'd1 || wd !== 64'h71 || req_ready !== 4'b0100) begin
            nFails++;
            $display("FAIL fair_grant1: gid=%0d wd=%h ready=%b want 1/71/0100",
                     grant_id, wd, req_ready);
        end
        step();
        req_valid = 4'b0010;
        #1;
        nChecks++;
        if (grant_id !== 2'd2 || wd !== 64'h72 || req_ready !== 4'b0010) begin
            nFails++;
            $display("FAIL fair_grant2: gid=%0d wd=%h ready=%b want 2/72/0010",
                     grant_id, wd, req_ready);
        end
        step();
        req_valid = '0;
        nChecks++;
        if (w !== 1'b1 || grant_id !== 2'd1 || wd !== 64'h73) begin
            nFails++;
            $display("FAIL fair_grant3: w=%b gid=%0d wd=%h want 1/1/73", w, grant_id, wd);
        end
        step();
        nChecks++;
        if (mem[7] !== 64'h73) begin
            nFails++;
            $display("FAIL same_addr_last_wins: reg7=%h want 73", mem[7]);
        end
    endtask

    task automatic test_midreset();
        req_valid = 4'b1111;
        step();
        rst = 1'b0;
        #1;
        nChecks++;
        if (req_ready !== 4'b0000) begin
            nFails++;
            $display("FAIL midreset_ready: got %b want 0000", req_ready);
        end
        step();
        rst = 1'b1;
        req_valid = '0;
        nChecks++;
        if (w !== 1'b0 || init_done !== 1'b0 || wa !== 5'd0 || grant_id !== 2'd0) begin
            nFails++;
            $display("FAIL midreset_clear: w=%b done=%b wa=%0d gid=%0d want 0/0/0/0",
                     w, init_done, wa, grant_id);
        end
        step();
        nChecks++;
        if (w !== 1'b1 || wa !== 5'd0 || wd !== '0 || init_done !== 1'b0) begin
            nFails++;
            $display("FAIL midreset_sweep0: w=%b wa=%0d wd=%h done=%b want 1/0/0/0",
                     w, wa, wd, init_done);
        end
        step();
        nChecks++;
        if (w !== 1'b1 || wa !== 5'd1) begin
            nFails++;
            $display("FAIL midreset_sweep1: w=%b wa=%0d want 1/1", w, wa);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nChecks   = 0;
        nFails    = 0;
        rst       = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_sweep();
        test_single();
        test_x0();
        test_contention();
        test_fairness();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
